// File: rtl/sevenseg_pkg.sv
// Shared glyph codes and segment patterns for the eight-digit seven-segment scan driver.
// Segment patterns are active-high, bit order gfedcba.
package sevenseg_pkg;

    localparam logic [4:0] CODE_BLANK = 5'h10;
    localparam logic [4:0] CODE_MINUS = 5'h11;
    localparam logic [4:0] CODE_L     = 5'h12;
    localparam logic [4:0] CODE_R     = 5'h13;
    localparam logic [4:0] CODE_O     = 5'h14;
    localparam logic [4:0] CODE_U     = 5'h15;
    localparam logic [4:0] CODE_P     = 5'h16;
    localparam logic [4:0] CODE_H     = 5'h17;

    localparam logic [6:0] GLYPH_BLANK = 7'h00;
    localparam logic [6:0] GLYPH_MINUS = 7'h40;
    localparam logic [6:0] GLYPH_L     = 7'h38;
    localparam logic [6:0] GLYPH_R     = 7'h50;
    localparam logic [6:0] GLYPH_O     = 7'h5C;
    localparam logic [6:0] GLYPH_U     = 7'h3E;
    localparam logic [6:0] GLYPH_P     = 7'h73;
    localparam logic [6:0] GLYPH_H     = 7'h76;

    localparam logic [6:0] GLYPH_HEX [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_ON    = 1'b1
    } phase_t;

endpackage

// File: rtl/sevenseg_glyph_decode.sv
// Combinational glyph lookup: 5-bit digit code to active-high gfedcba segment pattern.
module sevenseg_glyph_decode
    import sevenseg_pkg::*;
(
    input  logic [4:0] i_code,
    output logic [6:0] o_glyph
);

    always_comb begin
        o_glyph = GLYPH_BLANK;
        if (!i_code[4]) begin
            o_glyph = GLYPH_HEX[i_code[3:0]];
        end else begin
            case (i_code)
                CODE_MINUS: o_glyph = GLYPH_MINUS;
                CODE_L:     o_glyph = GLYPH_L;
                CODE_R:     o_glyph = GLYPH_R;
                CODE_O:     o_glyph = GLYPH_O;
                CODE_U:     o_glyph = GLYPH_U;
                CODE_P:     o_glyph = GLYPH_P;
                CODE_H:     o_glyph = GLYPH_H;
                default:    o_glyph = GLYPH_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/sevenseg_scan_driver.sv
// Eight-digit multiplexed seven-segment driver with per-frame input snapshot and
// an all-anodes-off gap at the start of every digit slot. All outputs registered, active-low.
module sevenseg_scan_driver
    import sevenseg_pkg::*;
#(
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int BLANK_TICKS     = 1000
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic [4:0] i_dig0,
    input  logic [4:0] i_dig1,
    input  logic [4:0] i_dig2,
    input  logic [4:0] i_dig3,
    input  logic [4:0] i_dig4,
    input  logic [4:0] i_dig5,
    input  logic [4:0] i_dig6,
    input  logic [4:0] i_dig7,
    input  logic [7:0] i_dp,
    output logic [7:0] o_an_n,
    output logic [6:0] o_seg_n,
    output logic       o_dp_n,
    output logic       o_frame_start
);

    localparam int TW = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_DIGIT - 1);

    logic [2:0]    r_idx;
    logic [TW-1:0] r_tick;
    logic [4:0]    r_shadow [8];
    logic [7:0]    r_shadow_dp;
    logic          r_load_pending;
    logic [7:0]    r_an_n;
    logic [6:0]    r_seg_n;
    logic          r_dp_n;
    logic          r_frame_start;

    logic [4:0]    w_dig [8];
    logic          w_tick_last;
    logic          w_load;
    logic [4:0]    w_code;
    logic [6:0]    w_glyph;
    phase_t        w_phase;

    assign w_dig[0] = i_dig0;
    assign w_dig[1] = i_dig1;
    assign w_dig[2] = i_dig2;
    assign w_dig[3] = i_dig3;
    assign w_dig[4] = i_dig4;
    assign w_dig[5] = i_dig5;
    assign w_dig[6] = i_dig6;
    assign w_dig[7] = i_dig7;

    assign w_tick_last = (r_tick == TICK_LAST);
    // Snapshot only at the digit-7 to digit-0 wrap so a frame never mixes old and new codes.
    assign w_load      = r_load_pending | (w_tick_last & (r_idx == 3'd7));
    assign w_code      = r_shadow[r_idx];

    generate
        if (BLANK_TICKS == 0) begin : g_no_blank
            assign w_phase = PH_ON;
        end else begin : g_blank
            localparam logic [TW-1:0] BLANK_END = TW'(BLANK_TICKS);
            assign w_phase = (r_tick < BLANK_END) ? PH_BLANK : PH_ON;
        end
    endgenerate

    sevenseg_glyph_decode u_glyph (
        .i_code  (w_code),
        .o_glyph (w_glyph)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_idx  <= 3'd0;
            r_tick <= '0;
        end else if (w_tick_last) begin
            r_tick <= '0;
            r_idx  <= r_idx + 3'd1;
        end else begin
            r_tick <= r_tick + 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int i = 0; i < 8; i++) r_shadow[i] <= CODE_BLANK;
            r_shadow_dp    <= 8'h00;
            r_load_pending <= 1'b1;
        end else if (w_load) begin
            for (int i = 0; i < 8; i++) r_shadow[i] <= w_dig[i];
            r_shadow_dp    <= i_dp;
            r_load_pending <= 1'b0;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_an_n        <= 8'hFF;
            r_seg_n       <= 7'h7F;
            r_dp_n        <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= w_load;
            if (w_phase == PH_BLANK) begin
                r_an_n  <= 8'hFF;
                r_seg_n <= 7'h7F;
                r_dp_n  <= 1'b1;
            end else begin
                r_an_n  <= ~(8'b1 << r_idx);
                r_seg_n <= ~w_glyph;
                r_dp_n  <= ~r_shadow_dp[r_idx];
            end
        end
    end

    assign o_an_n        = r_an_n;
    assign o_seg_n       = r_seg_n;
    assign o_dp_n        = r_dp_n;
    assign o_frame_start = r_frame_start;

endmodule

// File: tb/tb_sevenseg_scan_driver.sv
// Directed bench for sevenseg_scan_driver with TICKS_PER_DIGIT=8, one instance with
// BLANK_TICKS=2 and one with BLANK_TICKS=0, sharing stimulus.
module tb_sevenseg_scan_driver;

    localparam int T = 8;
    localparam int B = 2;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [4:0] dig [8];
    logic [7:0] dp;

    logic [7:0] a_an, z_an;
    logic [6:0] a_seg, z_seg;
    logic       a_dp, z_dp, a_fs, z_fs;

    int vectors     = 0;
    int miscompares = 0;

    // Reference snapshot of what the display should currently be showing.
    logic [4:0] frm [8];
    logic [7:0] frm_dp;

    always #5 clk = ~clk;

    sevenseg_scan_driver #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(B)) dut_a (
        .i_clk(clk), .i_reset(reset),
        .i_dig0(dig[0]), .i_dig1(dig[1]), .i_dig2(dig[2]), .i_dig3(dig[3]),
        .i_dig4(dig[4]), .i_dig5(dig[5]), .i_dig6(dig[6]), .i_dig7(dig[7]),
        .i_dp(dp),
        .o_an_n(a_an), .o_seg_n(a_seg), .o_dp_n(a_dp), .o_frame_start(a_fs)
    );

    sevenseg_scan_driver #(.TICKS_PER_DIGIT(T), .BLANK_TICKS(0)) dut_z (
        .i_clk(clk), .i_reset(reset),
        .i_dig0(dig[0]), .i_dig1(dig[1]), .i_dig2(dig[2]), .i_dig3(dig[3]),
        .i_dig4(dig[4]), .i_dig5(dig[5]), .i_dig6(dig[6]), .i_dig7(dig[7]),
        .i_dp(dp),
        .o_an_n(z_an), .o_seg_n(z_seg), .o_dp_n(z_dp), .o_frame_start(z_fs)
    );

    function automatic logic [6:0] glyph_ref(input logic [4:0] code);
        case (code)
            5'h00: return 7'h3F;  5'h01: return 7'h06;  5'h02: return 7'h5B;  5'h03: return 7'h4F;
            5'h04: return 7'h66;  5'h05: return 7'h6D;  5'h06: return 7'h7D;  5'h07: return 7'h07;
            5'h08: return 7'h7F;  5'h09: return 7'h6F;  5'h0A: return 7'h77;  5'h0B: return 7'h7C;
            5'h0C: return 7'h39;  5'h0D: return 7'h5E;  5'h0E: return 7'h79;  5'h0F: return 7'h71;
            5'h11: return 7'h40;  5'h12: return 7'h38;  5'h13: return 7'h50;  5'h14: return 7'h5C;
            5'h15: return 7'h3E;  5'h16: return 7'h73;  5'h17: return 7'h76;
            default: return 7'h00;
        endcase
    endfunction

    // Expected {an_n, seg_n, dp_n, frame_start} after the c-th edge following reset release.
    function automatic logic [16:0] exp_out(input int c, input int blank);
        int tick = c % T;
        int idx  = (c / T) % 8;
        logic fs = (c == 0) || (c % (8 * T) == 8 * T - 1);
        logic [7:0] an = 8'hFF;
        if (tick < blank) return {8'hFF, 7'h7F, 1'b1, fs};
        an[idx] = 1'b0;
        return {an, ~glyph_ref(frm[idx]), ~frm_dp[idx], fs};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic snap_if(input int c);
        if ((c == 0) || (c % (8 * T) == 8 * T - 1)) begin
            for (int k = 0; k < 8; k++) frm[k] = dig[k];
            frm_dp = dp;
        end
    endtask

    task automatic start();
        reset = 1'b1;
        for (int k = 0; k < 8; k++) frm[k] = 5'h10;
        frm_dp = 8'h00;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 8; k++) dig[k] = 5'(k);
        dp = 8'h00;
        reset = 1'b1;
        step();
        vectors++;
        if ({a_an, a_seg, a_dp, a_fs} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_a got %h/%h/%b/%b want ff/7f/1/0", a_an, a_seg, a_dp, a_fs);
        end
        vectors++;
        if ({z_an, z_seg, z_dp, z_fs} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_z got %h/%h/%b/%b want ff/7f/1/0", z_an, z_seg, z_dp, z_fs);
        end
    endtask

    task automatic test_scan();
        logic [16:0] e;
        for (int k = 0; k < 8; k++) dig[k] = 5'(k);
        dp = 8'h00;
        start();
        for (int c = 0; c < 72; c++) begin
            step();
            e = exp_out(c, B);
            vectors++;
            if ({a_an, a_seg, a_dp, a_fs} !== e) begin
                miscompares++;
                $display("FAIL scan c=%0d got %h/%h/%b/%b want %h/%h/%b/%b", c,
                         a_an, a_seg, a_dp, a_fs, e[16:9], e[8:2], e[1], e[0]);
            end
            if (c == 2 || c == 10) begin
                vectors++;
                if ({a_an, a_seg} !== ((c == 2) ? {8'hFE, 7'h40} : {8'hFD, 7'h79})) begin
                    miscompares++;
                    $display("FAIL scan_digit c=%0d got %h/%h", c, a_an, a_seg);
                end
            end
            snap_if(c);
        end
    endtask

    task automatic test_no_tearing();
        logic [16:0] e;
        for (int k = 0; k < 8; k++) dig[k] = 5'(k);
        dp = 8'h00;
        start();
        for (int c = 0; c < 136; c++) begin
            if (c == 8) dig[3] = 5'h11;
            step();
            e = exp_out(c, B);
            vectors++;
            if ({a_an, a_seg, a_dp, a_fs} !== e) begin
                miscompares++;
                $display("FAIL tearing c=%0d got %h/%h/%b/%b want %h/%h/%b/%b", c,
                         a_an, a_seg, a_dp, a_fs, e[16:9], e[8:2], e[1], e[0]);
            end
            if (c == 26 || c == 90) begin
                vectors++;
                if ({a_an, a_seg} !== ((c == 26) ? {8'hF7, 7'h30} : {8'hF7, 7'h3F})) begin
                    miscompares++;
                    $display("FAIL tearing_digit3 c=%0d got %h/%h", c, a_an, a_seg);
                end
            end
            snap_if(c);
        end
    endtask

    task automatic test_dp();
        logic [16:0] e;
        for (int k = 0; k < 8; k++) dig[k] = 5'(k);
        dig[0] = 5'h0A;
        dig[7] = 5'h1F;
        dp = 8'h81;
        start();
        for (int c = 0; c < 72; c++) begin
            step();
            e = exp_out(c, B);
            vectors++;
            if ({a_an, a_seg, a_dp, a_fs} !== e) begin
                miscompares++;
                $display("FAIL dp c=%0d got %h/%h/%b/%b want %h/%h/%b/%b", c,
                         a_an, a_seg, a_dp, a_fs, e[16:9], e[8:2], e[1], e[0]);
            end
            if (c == 2 || c == 58 || c == 10) begin
                vectors++;
                if ({a_an, a_seg, a_dp} !== ((c == 2)  ? {8'hFE, 7'h08, 1'b0} :
                                             (c == 58) ? {8'h7F, 7'h7F, 1'b0} :
                                                         {8'hFD, 7'h79, 1'b1})) begin
                    miscompares++;
                    $display("FAIL dp_digit c=%0d got %h/%h/%b", c, a_an, a_seg, a_dp);
                end
            end
            snap_if(c);
        end
    endtask

    task automatic test_reset_mid_scan();
        logic [16:0] e;
        for (int k = 0; k < 8; k++) dig[k] = 5'(7 - k);
        dp = 8'h20;
        start();
        for (int c = 0; c <= 44; c++) begin
            step();
            snap_if(c);
        end
        vectors++;
        if ({a_an, a_seg, a_dp} !== {8'hDF, ~glyph_ref(5'd2), 1'b0}) begin
            miscompares++;
            $display("FAIL midscan_pre got %h/%h/%b", a_an, a_seg, a_dp);
        end
        reset = 1'b1;
        #1;
        vectors++;
        if ({a_an, a_seg, a_dp, a_fs} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL midscan_async_a got %h/%h/%b/%b want ff/7f/1/0", a_an, a_seg, a_dp, a_fs);
        end
        vectors++;
        if ({z_an, z_seg, z_dp} !== {8'hFF, 7'h7F, 1'b1}) begin
            miscompares++;
            $display("FAIL midscan_async_z got %h/%h/%b want ff/7f/1", z_an, z_seg, z_dp);
        end
        start();
        for (int c = 0; c < 24; c++) begin
            step();
            e = exp_out(c, B);
            vectors++;
            if ({a_an, a_seg, a_dp, a_fs} !== e) begin
                miscompares++;
                $display("FAIL midscan_restart c=%0d got %h/%h/%b/%b want %h/%h/%b/%b", c,
                         a_an, a_seg, a_dp, a_fs, e[16:9], e[8:2], e[1], e[0]);
            end
            snap_if(c);
        end
    endtask

    task automatic test_random_frames();
        logic [16:0] e;
        int last_fs = -1;
        int on_cnt [8];
        for (int k = 0; k < 8; k++) on_cnt[k] = 0;
        for (int k = 0; k < 8; k++) dig[k] = 5'($urandom_range(0, 31));
        dp = 8'($urandom);
        start();
        for (int c = 0; c < 256; c++) begin
            for (int k = 0; k < 8; k++) dig[k] = 5'($urandom_range(0, 31));
            dp = 8'($urandom);
            step();
            e = exp_out(c, B);
            vectors++;
            if ({a_an, a_seg, a_dp, a_fs} !== e) begin
                miscompares++;
                $display("FAIL random c=%0d got %h/%h/%b/%b want %h/%h/%b/%b", c,
                         a_an, a_seg, a_dp, a_fs, e[16:9], e[8:2], e[1], e[0]);
            end
            vectors++;
            if ($countones(~a_an) > 1) begin
                miscompares++;
                $display("FAIL random_overlap c=%0d got an_n %h want at most one low", c, a_an);
            end
            if (a_fs === 1'b1) begin
                if (last_fs > 0) begin
                    vectors++;
                    if (c - last_fs != 64) begin
                        miscompares++;
                        $display("FAIL random_period c=%0d got %0d want 64", c, c - last_fs);
                    end
                end
                last_fs = c;
            end
            if (c >= 64 && c < 128) begin
                for (int k = 0; k < 8; k++) if (a_an[k] === 1'b0) on_cnt[k]++;
            end
            snap_if(c);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (on_cnt[k] != 6) begin
                miscompares++;
                $display("FAIL random_on_count digit %0d got %0d want 6", k, on_cnt[k]);
            end
        end
    endtask

    task automatic test_no_blank();
        logic [16:0] e;
        int on_cnt [8];
        for (int k = 0; k < 8; k++) on_cnt[k] = 0;
        for (int k = 0; k < 8; k++) dig[k] = 5'(k);
        dp = 8'h00;
        start();
        for (int c = 0; c < 72; c++) begin
            step();
            e = exp_out(c, 0);
            vectors++;
            if ({z_an, z_seg, z_dp, z_fs} !== e) begin
                miscompares++;
                $display("FAIL noblank c=%0d got %h/%h/%b/%b want %h/%h/%b/%b", c,
                         z_an, z_seg, z_dp, z_fs, e[16:9], e[8:2], e[1], e[0]);
            end
            vectors++;
            if (z_an === 8'hFF) begin
                miscompares++;
                $display("FAIL noblank_gap c=%0d got an_n ff want one digit low", c);
            end
            if (c < 64) begin
                for (int k = 0; k < 8; k++) if (z_an[k] === 1'b0) on_cnt[k]++;
            end
            snap_if(c);
        end
        for (int k = 0; k < 8; k++) begin
            vectors++;
            if (on_cnt[k] != 8) begin
                miscompares++;
                $display("FAIL noblank_on_count digit %0d got %0d want 8", k, on_cnt[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_scan();
        test_no_tearing();
        test_dp();
        test_reset_mid_scan();
        test_random_frames();
        test_no_blank();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
